// File: rtl/ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_stage
// Purpose  : Instruction-fetch stage. Samples the PC, issues a single
//            outstanding req/ack fetch to instruction memory, holds the
//            returned word in the IF/ID register until decode takes it, and
//            strobes pc_advance so next-PC logic loads the following PC.
//            Supports flush (redirect) and a request timeout (bus error).
// Ports    : clk, reset (async active-low)
//            pc, flush, id_ready                 - pipeline control inputs
//            imem_req/imem_addr/imem_ack/imem_rdata - memory handshake
//            instr, instr_pc, instr_valid        - IF/ID register
//            pc_advance                          - combinational PC load strobe
//            bus_err, misalign                   - sticky error flags
// Options  : IFETCH_MISALIGN_CHECK_EN - when defined, a PC with pc[1:0]!=0
//            blocks fetching and sets misalign; when undefined the low two
//            PC bits are masked off and misalign is tied 0.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_stage #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic              id_ready,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              pc_advance,
    output logic              bus_err,
    output logic              misalign
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [7:0]        c_TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] c_WORD_MASK    = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t            r_state;
    logic [7:0]        r_count;
    logic              w_timed_out;
    logic              w_pc_misaligned;
    logic [ADDR_W-1:0] w_fetch_addr;

    // Count keeps running across REQ->DRAIN, so ">=" guarantees the bound
    // still fires even if a flush bumped the count past TIMEOUT-1.
    assign w_timed_out = (r_count >= c_TIMEOUT_LAST);

`ifdef IFETCH_MISALIGN_CHECK_EN
    logic r_misalign;
    assign w_pc_misaligned = (pc[1:0] != 2'b00);
    assign w_fetch_addr    = pc;
    assign misalign        = r_misalign;
`else
    assign w_pc_misaligned = 1'b0;
    assign w_fetch_addr    = pc & c_WORD_MASK;
    assign misalign        = 1'b0;
`endif

    assign pc_advance = (r_state == S_HOLD) && id_ready && !flush;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_count     <= 8'd0;
            imem_req    <= 1'b0;
            imem_addr   <= '0;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            bus_err     <= 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            r_misalign  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!flush && !bus_err && !misalign) begin
                        if (w_pc_misaligned) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                            r_misalign <= 1'b1;
`endif
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= w_fetch_addr;
                            r_count   <= 8'd0;
                            r_state   <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (flush) begin
                            r_state <= S_IDLE;
                        end else begin
                            instr       <= imem_rdata;
                            instr_pc    <= imem_addr;
                            instr_valid <= 1'b1;
                            r_state     <= S_HOLD;
                        end
                    end else if (flush) begin
                        // Request stays on the bus; its data is dropped later.
                        r_count <= r_count + 8'd1;
                        r_state <= S_DRAIN;
                    end else if (w_timed_out) begin
                        bus_err     <= 1'b1;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        r_state  <= S_IDLE;
                    end else if (w_timed_out) begin
                        bus_err     <= 1'b1;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (flush || id_ready) begin
                        instr_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifetch_stage
// Purpose  : Self-checking bench for ifetch_stage. A transaction-level
//            reference model tracks what the fetch stage must present and is
//            compared against every output once per cycle; directed literal
//            checks pin reset, basic fetch, backpressure, flush, misalign,
//            timeout and asynchronous reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifetch_stage;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] pc;
    logic              flush;
    logic              id_ready;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              pc_advance;
    logic              bus_err;
    logic              misalign;

    int tests = 0;
    int fails = 0;

    ifetch_stage #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .pc(pc), .flush(flush), .id_ready(id_ready),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .pc_advance(pc_advance), .bus_err(bus_err),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (transaction level) ----------------
    bit        m_req, m_drop, m_hold, m_berr, m_mis;
    logic [31:0] m_addr, m_instr, m_ipc;
    int        m_wait;

    task automatic model_reset();
        m_req = 0; m_drop = 0; m_hold = 0; m_berr = 0; m_mis = 0;
        m_addr = 0; m_instr = 0; m_ipc = 0; m_wait = 0;
    endtask

    // Called right after each rising edge, with the inputs that edge saw.
    task automatic model_step();
        if (m_hold) begin
            if (flush || id_ready) m_hold = 0;
        end else if (m_req) begin
            if (imem_ack) begin
                m_req = 0;
                if (!m_drop && !flush) begin
                    m_hold = 1; m_instr = imem_rdata; m_ipc = m_addr;
                end
            end else if (flush && !m_drop) begin
                m_drop = 1; m_wait++;
            end else if (m_wait >= TIMEOUT - 1) begin
                m_berr = 1; m_req = 0;
            end else begin
                m_wait++;
            end
        end else if (!flush && !m_berr && !m_mis) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) m_mis = 1;
            else begin m_req = 1; m_drop = 0; m_wait = 0; m_addr = pc; end
`else
            m_req = 1; m_drop = 0; m_wait = 0; m_addr = {pc[31:2], 2'b00};
`endif
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("imem_req",    {63'd0, imem_req},    {63'd0, m_req});
        chk("imem_addr",   {32'd0, imem_addr},   {32'd0, m_addr});
        chk("instr_valid", {63'd0, instr_valid}, {63'd0, m_hold});
        chk("instr",       {32'd0, instr},       {32'd0, m_instr});
        chk("instr_pc",    {32'd0, instr_pc},    {32'd0, m_ipc});
        chk("pc_advance",  {63'd0, pc_advance},  {63'd0, (m_hold && id_ready && !flush)});
        chk("bus_err",     {63'd0, bus_err},     {63'd0, m_berr});
        chk("misalign",    {63'd0, misalign},    {63'd0, m_mis});
    endtask

    // Inputs are applied 1 time unit after the edge and checked 1 unit later.
    task automatic apply(input logic f, input logic idr, input logic a,
                         input logic [31:0] rd, input logic [31:0] p);
        flush = f; id_ready = idr; imem_ack = a; imem_rdata = rd; pc = p;
        #1;
        compare();
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        flush = 0; id_ready = 0; imem_ack = 0; imem_rdata = 0; pc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev_req;
        int age, lat;
        logic f, idr, a;
        logic [31:0] p;

        do_reset();
        // reset state
        chk("rst_imem_req",    {63'd0, imem_req},    64'd0);
        chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_bus_err",     {63'd0, bus_err},     64'd0);
        chk("rst_instr",       {32'd0, instr},       64'd0);

        // basic fetch, 1-cycle memory latency
        apply(0, 1, 0, 0, 32'h0); step();
        chk("bf_req",  {63'd0, imem_req}, 64'd1);
        chk("bf_addr", {32'd0, imem_addr}, 64'h0);
        apply(0, 1, 1, 32'h2008000A, 32'h0); step();
        chk("bf_instr",   {32'd0, instr},    64'h2008000A);
        chk("bf_ipc",     {32'd0, instr_pc}, 64'h0);
        chk("bf_valid",   {63'd0, instr_valid}, 64'd1);
        apply(0, 1, 0, 0, 32'h0);
        chk("bf_adv_hi",  {63'd0, pc_advance}, 64'd1);
        step();
        apply(0, 1, 0, 0, 32'h4);
        chk("bf_adv_lo",  {63'd0, pc_advance}, 64'd0);
        step();
        chk("bf_next_addr", {32'd0, imem_addr}, 64'h4);
        apply(0, 0, 1, 32'h11112222, 32'h4); step();

        // backpressure: decode stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 32'h4);
            chk("bp_adv",   {63'd0, pc_advance}, 64'd0);
            chk("bp_valid", {63'd0, instr_valid}, 64'd1);
            chk("bp_instr", {32'd0, instr}, 64'h11112222);
            chk("bp_noreq", {63'd0, imem_req}, 64'd0);
            step();
        end
        apply(0, 1, 0, 0, 32'h4);
        chk("bp_adv_hi", {63'd0, pc_advance}, 64'd1);
        step();

        // flush while request is pending
        apply(0, 1, 0, 0, 32'h324); step();
        chk("fl_addr", {32'd0, imem_addr}, 64'h324);
        apply(1, 1, 0, 0, 32'h100); step();
        chk("fl_req_held", {63'd0, imem_req}, 64'd1);
        apply(0, 1, 0, 0, 32'h100); step();
        apply(0, 1, 0, 0, 32'h100); step();
        chk("fl_req_held2", {63'd0, imem_req}, 64'd1);
        apply(0, 1, 1, 32'hDEADBEEF, 32'h100); step();
        chk("fl_req_drop", {63'd0, imem_req}, 64'd0);
        chk("fl_novalid",  {63'd0, instr_valid}, 64'd0);
        apply(0, 1, 0, 0, 32'h100); step();
        chk("fl_new_addr", {32'd0, imem_addr}, 64'h100);
        apply(0, 1, 1, 32'hCAFE0001, 32'h100); step();
        apply(0, 1, 0, 0, 32'h104); step();

        // misaligned PC
        apply(0, 1, 0, 0, 32'h806); step();
`ifdef IFETCH_MISALIGN_CHECK_EN
        chk("mis_flag",  {63'd0, misalign}, 64'd1);
        chk("mis_noreq", {63'd0, imem_req}, 64'd0);
        apply(0, 1, 0, 0, 32'h800); step();
        chk("mis_sticky", {63'd0, imem_req}, 64'd0);
`else
        chk("mis_addr", {32'd0, imem_addr}, 64'h804);
        apply(0, 1, 1, 32'h0BADF00D, 32'h806); step();
        chk("mis_ipc", {32'd0, instr_pc}, 64'h804);
        apply(0, 1, 0, 0, 32'h808); step();
`endif

        // randomized traffic
        do_reset();
        age = 0; lat = 0;
        for (int i = 0; i < 600; i++) begin
            f   = ($urandom_range(0, 7) == 0);
            idr = ($urandom_range(0, 2) != 0);
            a   = m_req && (age >= lat);
            p   = ($urandom_range(0, 63) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
            apply(f, idr, a, $urandom(), p);
            prev_req = m_req;
            step();
            if (m_req && !prev_req) begin
                age = 0; lat = $urandom_range(0, 4);
            end else if (m_req) begin
                age++;
            end
        end

        // timeout: memory never answers
        do_reset();
        apply(0, 1, 0, 0, 32'h40); step();
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            apply(0, 1, 0, 0, 32'h40); step();
            chk("to_not_yet", {63'd0, bus_err}, 64'd0);
        end
        apply(0, 1, 0, 0, 32'h40); step();
        chk("to_berr",  {63'd0, bus_err}, 64'd1);
        chk("to_noreq", {63'd0, imem_req}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            apply(0, 1, 0, 0, 32'h44); step();
            chk("to_stopped", {63'd0, imem_req}, 64'd0);
        end

        // asynchronous reset mid-REQ
        do_reset();
        apply(0, 1, 0, 0, 32'h20); step();
        apply(0, 1, 1, 32'h12345678, 32'h20); step();
        apply(0, 1, 0, 0, 32'h20); step();
        apply(0, 1, 0, 0, 32'h24); step();
        chk("ar_pre_req", {63'd0, imem_req}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_req",   {63'd0, imem_req},    64'd0);
        chk("ar_valid", {63'd0, instr_valid}, 64'd0);
        chk("ar_berr",  {63'd0, bus_err},     64'd0);
        chk("ar_instr", {32'd0, instr},       64'd0);
        chk("ar_ipc",   {32'd0, instr_pc},    64'd0);
        chk("ar_addr",  {32'd0, imem_addr},   64'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        apply(0, 1, 0, 0, 32'h0); step();
        apply(0, 1, 0, 0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage directly downstream of the program counter register. It consumes the PC value and fetches the instruction word from instruction memory over a req/ack handshake.
- It holds the fetched word in the IF/ID register until decode accepts it.
- It generates the pc_advance strobe that tells next-PC logic to load the next PC into the PC register.
- Single outstanding fetch; flush support for branch/jump redirects; timeout-based bus error.

Parameters:
- ADDR_W, 32, width of PC and instruction-memory address.
- DATA_W, 32, instruction word width.
- TIMEOUT, 16, cycles an imem request may wait for ack before bus error; legal range 2..255.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; reset==0 clears all state immediately.
- pc  input  ADDR_W  current PC from the PC register.
- flush  input  1  synchronous redirect: discard the in-flight or held instruction.
- id_ready  input  1  decode stage can accept the held instruction this cycle.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  ADDR_W  fetch address, registered; stable while imem_req=1.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  DATA_W  instruction word, valid when imem_ack=1.
- instr  output  DATA_W  IF/ID instruction register.
- instr_pc  output  ADDR_W  address the held instruction was fetched from.
- instr_valid  output  1  instr/instr_pc hold a valid instruction.
- pc_advance  output  1  combinational; equals (state==HOLD && id_ready && !flush).
- bus_err  output  1  sticky fetch-timeout flag.
- misalign  output  1  sticky misaligned-PC flag; see Optional Feature.

Behaviour:
- Reset (reset==0, async): state=IDLE; imem_req=0, imem_addr=0, instr=0, instr_pc=0, instr_valid=0, bus_err=0, misalign=0, timeout count=0.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: if !flush && !bus_err (and !misalign), at the next edge: imem_req<=1, imem_addr<=pc, count<=0, go to REQ.
- REQ:
  - imem_req and imem_addr are held until imem_ack is sampled 1.
  - On ack: instr<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, go to HOLD.
  - ack arriving in the same cycle the request is first presented is legal, giving 1-cycle memory latency.
- HOLD: instr_valid=1 and instr stays stable. On id_ready=1: handoff at the edge; instr_valid<=0, go to IDLE. pc_advance is high during the handoff cycle, so the PC register loads its new value at the same edge; IDLE then fetches the new PC.
- Throughput: with 1-cycle ack and id_ready tied 1, one instruction every 3 cycles (IDLE, REQ, HOLD).
- flush (priority over everything except reset):
  - In IDLE: no request issued.
  - In HOLD: instr_valid<=0, go to IDLE; pc_advance is suppressed.
  - In REQ with ack in the same cycle: data discarded, imem_req<=0, go to IDLE.
  - In REQ without ack: go to DRAIN. A request is never withdrawn before ack.
- DRAIN: imem_req held until ack; data discarded; imem_req<=0, go to IDLE. flush asserted again during DRAIN has no further effect.
- Timeout: count increments each REQ/DRAIN cycle without ack. When count reaches TIMEOUT-1 without ack: bus_err<=1, imem_req<=0, instr_valid<=0, go to IDLE. Fetching stops until reset.
- instr_pc/instr retain their last values after handoff or flush; only instr_valid qualifies them.
- ADDR arithmetic: none internally; PC increment belongs to next-PC logic.

Optional Feature:
- Macro IFETCH_MISALIGN_CHECK_EN.
- Defined: in IDLE, if pc[1:0]!=2'b00, no request is issued; misalign<=1 (sticky until reset) and the block stays in IDLE.
- Undefined: imem_addr is driven as {pc[ADDR_W-1:2],2'b00}, instr_pc records the same value, and misalign is tied 0.

Test Plan:
- Reset: drive reset=0 mid-REQ with imem_req=1 -> imem_req, instr_valid, bus_err, instr, and instr_pc all read 0 immediately, before the next clk edge.
- Basic fetch: pc=0x0, ack 1 cycle after req, rdata=0x2008000A, id_ready=1 -> imem_addr=0x0, then instr=0x2008000A, instr_pc=0x0, instr_valid=1; pc_advance high for exactly 1 cycle; the next request uses pc=0x4.
- Backpressure: id_ready=0 for 5 cycles after fetch -> instr_valid stays 1, instr stable, pc_advance=0, no new imem_req; id_ready=1 -> handoff and one pc_advance pulse.
- Flush in REQ: req to 0x324 pending, flush for 1 cycle, ack 3 cycles later with 0xDEADBEEF -> imem_req held until ack, instr_valid never 1, next request uses the new pc=0x100.
- Timeout: TIMEOUT=16, ack never asserted -> bus_err=1 after 16 REQ cycles, imem_req=0, no further requests until reset.
- Misalign (IFETCH_MISALIGN_CHECK_EN defined): pc=0x806 -> misalign=1, imem_req stays 0. Macro undefined: imem_addr=0x804.
